// File: rtl/mdl_sata_pkg.sv
// Package: mdl_sata_pkg
// Shared definitions for the SATA transmit-side bench models.
//   sched_state_e : word-scheduler slot state (S_IDLE/S_WAKE/S_RUN/S_ALIGN)
//   ALIGNP_WORD   : encoded ALIGNp primitive (K28.5 D10.2 D10.2 D27.3)
//   SYNCP_WORD    : filler word sent when no upstream data is offered
package mdl_sata_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAKE  = 2'd1,
    S_RUN   = 2'd2,
    S_ALIGN = 2'd3
  } sched_state_e;

  localparam logic [39:0] ALIGNP_WORD = 40'h3E9555549C;
  localparam logic [39:0] SYNCP_WORD  = 40'hAAAAAAAAAA;

endpackage

// File: rtl/mdl_word_timer.sv
// Module: mdl_word_timer
// Tracks the serializer word boundary on the bit clock.
// Ports:
//   i_clk   : bit clock, shared with the serializer
//   i_reset : asynchronous active-high reset (bit counter returns to 0)
//   o_load  : high during the last bit of each word (serializer load cycle)
module mdl_word_timer #(
  parameter int unsigned WORD_SIZE = 40
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_load
);

  localparam int unsigned    BcW    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BcW-1:0] BcLast = BcW'(WORD_SIZE - 1);

  logic [BcW-1:0] r_bc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bc <= '0;
    end else if (r_bc == BcLast) begin
      r_bc <= '0;
    end else begin
      r_bc <= r_bc + 1'b1;
    end
  end

  assign o_load = (r_bc == BcLast);

endmodule

// File: rtl/mdl_tx_word_sched.sv
// Module: mdl_tx_word_sched
// Bench-side TX word scheduler feeding the 40-bit serial transmit model.
// Once per word slot it chooses electrical idle, ALIGNp, upstream data or
// SYNC filler; inserts an ALIGNp pair every ALIGN_INTERVAL words and an
// ALIGNp burst of ALIGN_BURST words on wake from idle.
// Ports:
//   i_clk, i_reset   : bit clock; asynchronous active-high reset
//   i_idle_req       : request electrical idle
//   s_valid/s_data   : upstream word offer
//   s_ready          : word accepted this cycle (combinational, load cycle only)
//   o_elec_idle      : to serializer electrical-idle input
//   o_data           : to serializer parallel data input
//   o_word_strobe    : high on each serializer load cycle
//   o_align_count    : ALIGNp words issued   (MDL_TXSCHED_STATS_EN only)
//   o_data_count     : data words accepted   (MDL_TXSCHED_STATS_EN only)
// Configuration macro: MDL_TXSCHED_STATS_EN adds the two statistics counters.
module mdl_tx_word_sched
  import mdl_sata_pkg::*;
#(
  parameter int unsigned          WORD_SIZE      = 40,
  parameter int unsigned          ALIGN_INTERVAL = 256,
  parameter int unsigned          ALIGN_BURST    = 2,
  parameter logic [WORD_SIZE-1:0] ALIGN_WORD     = WORD_SIZE'(ALIGNP_WORD),
  parameter logic [WORD_SIZE-1:0] SYNC_WORD      = WORD_SIZE'(SYNCP_WORD)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_idle_req,
  input  logic                 s_valid,
  input  logic [WORD_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 o_elec_idle,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_word_strobe
`ifdef MDL_TXSCHED_STATS_EN
  ,
  output logic [31:0]          o_align_count,
  output logic [31:0]          o_data_count
`endif
);

  localparam int unsigned    IcW   = $clog2(ALIGN_INTERVAL + 1);
  localparam int unsigned    WkW   = $clog2(ALIGN_BURST + 1);
  localparam logic [IcW-1:0] IcMax = IcW'(ALIGN_INTERVAL);
  localparam logic [WkW-1:0] WkMax = WkW'(ALIGN_BURST);

  logic                 w_load;
  logic                 w_due;
  sched_state_e         r_state, w_state_nxt;
  logic                 r_elec_idle, w_elec_idle_nxt;
  logic [WORD_SIZE-1:0] r_data, w_data_nxt;
  logic [IcW-1:0]       r_ic, w_ic_nxt;
  logic [WkW-1:0]       r_wk, w_wk_nxt;

  mdl_word_timer #(
    .WORD_SIZE(WORD_SIZE)
  ) u_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_load (w_load)
  );

  assign w_due   = (r_ic == IcMax);
  assign s_ready = w_load && (r_state == S_RUN) && !i_idle_req && !w_due;

  // Next-slot choice; only committed on load edges.
  always_comb begin
    w_state_nxt     = r_state;
    w_elec_idle_nxt = r_elec_idle;
    w_data_nxt      = r_data;
    w_ic_nxt        = r_ic;
    w_wk_nxt        = r_wk;
    unique case (r_state)
      S_IDLE: begin
        if (i_idle_req) begin
          w_elec_idle_nxt = 1'b1;
          w_data_nxt      = '0;
        end else begin
          w_state_nxt     = S_WAKE;
          w_elec_idle_nxt = 1'b0;
          w_data_nxt      = ALIGN_WORD;
          w_wk_nxt        = WkW'(1);
        end
      end
      S_WAKE: begin
        if (i_idle_req) begin
          w_state_nxt     = S_IDLE;
          w_elec_idle_nxt = 1'b1;
          w_data_nxt      = '0;
        end else if (r_wk < WkMax) begin
          w_data_nxt = ALIGN_WORD;
          w_wk_nxt   = r_wk + 1'b1;
        end else begin
          // First run slot with ic starting at 0: never due (interval >= 1),
          // and s_ready is low outside S_RUN, so this slot carries SYNC.
          w_state_nxt = S_RUN;
          w_data_nxt  = SYNC_WORD;
          w_ic_nxt    = IcW'(1);
        end
      end
      S_RUN: begin
        if (i_idle_req) begin
          w_state_nxt     = S_IDLE;
          w_elec_idle_nxt = 1'b1;
          w_data_nxt      = '0;
        end else if (w_due) begin
          w_state_nxt = S_ALIGN;
          w_data_nxt  = ALIGN_WORD;
        end else if (s_valid) begin
          w_data_nxt = s_data;
          w_ic_nxt   = r_ic + 1'b1;
        end else begin
          w_data_nxt = SYNC_WORD;
          w_ic_nxt   = r_ic + 1'b1;
        end
      end
      S_ALIGN: begin
        // Second half of the pair; idle requests wait until it is out.
        w_state_nxt = S_RUN;
        w_data_nxt  = ALIGN_WORD;
        w_ic_nxt    = '0;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_elec_idle_nxt = 1'b1;
        w_data_nxt      = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_elec_idle <= 1'b1;
      r_data      <= '0;
      r_ic        <= '0;
      r_wk        <= '0;
    end else if (w_load) begin
      r_state     <= w_state_nxt;
      r_elec_idle <= w_elec_idle_nxt;
      r_data      <= w_data_nxt;
      r_ic        <= w_ic_nxt;
      r_wk        <= w_wk_nxt;
    end
  end

  assign o_elec_idle   = r_elec_idle;
  assign o_data        = r_data;
  assign o_word_strobe = w_load;

`ifdef MDL_TXSCHED_STATS_EN
  logic        w_align_slot;
  logic [31:0] r_align_count;
  logic [31:0] r_data_count;

  // ALIGNp goes out whenever the next state is WAKE/ALIGN, or when leaving
  // ALIGN (second of the pair). WAKE->RUN carries SYNC and is excluded.
  assign w_align_slot = (w_state_nxt == S_WAKE) || (w_state_nxt == S_ALIGN) ||
                        (r_state == S_ALIGN);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_align_count <= '0;
      r_data_count  <= '0;
    end else if (w_load) begin
      if (w_align_slot) r_align_count <= r_align_count + 32'd1;
      if (s_valid && s_ready) r_data_count <= r_data_count + 32'd1;
    end
  end

  assign o_align_count = r_align_count;
  assign o_data_count  = r_data_count;
`endif

endmodule

// File: tb/tb_mdl_tx_word_sched.sv
module tb_mdl_tx_word_sched;

  localparam int unsigned WS = 40;
  localparam int unsigned AI = 4;
  localparam int unsigned AB = 2;
  localparam logic [39:0] ALIGN_W = 40'h3E9555549C;
  localparam logic [39:0] SYNC_W  = 40'hAAAAAAAAAA;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_idle_req;
  logic        s_valid;
  logic [39:0] s_data;
  logic        s_ready;
  logic        o_elec_idle;
  logic [39:0] o_data;
  logic        o_word_strobe;
`ifdef MDL_TXSCHED_STATS_EN
  logic [31:0] o_align_count;
  logic [31:0] o_data_count;
`endif

  int errors = 0;
  int checks = 0;

  mdl_tx_word_sched #(
    .WORD_SIZE     (WS),
    .ALIGN_INTERVAL(AI),
    .ALIGN_BURST   (AB)
  ) u_dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_idle_req   (i_idle_req),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .o_elec_idle  (o_elec_idle),
    .o_data       (o_data),
    .o_word_strobe(o_word_strobe)
`ifdef MDL_TXSCHED_STATS_EN
    ,
    .o_align_count(o_align_count),
    .o_data_count (o_data_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Reference model of the line, one call per word slot.
  bit          m_active;     // line has left electrical idle
  bit          m_running;    // wake burst finished, normal traffic
  bit          m_pair_half;  // first ALIGNp of a periodic pair just sent
  int          m_burst;      // ALIGNp words sent in the current wake burst
  int          m_since;      // non-ALIGN words since the last pair
  bit          m_elec_idle;
  logic [39:0] m_data;
  int          m_n_align;
  int          m_n_data;

  function void model_reset();
    m_active = 0; m_running = 0; m_pair_half = 0; m_burst = 0; m_since = 0;
    m_elec_idle = 1; m_data = '0; m_n_align = 0; m_n_data = 0;
  endfunction

  function bit model_ready(input bit idle);
    return m_running && !m_pair_half && !idle && (m_since < AI);
  endfunction

  function void model_slot(input bit idle, input bit valid, input logic [39:0] d,
                           output bit accepted);
    accepted = model_ready(idle) && valid;
    if (m_pair_half) begin
      m_data = ALIGN_W; m_pair_half = 0; m_since = 0; m_n_align++;
    end else if (idle) begin
      m_elec_idle = 1; m_data = '0; m_active = 0; m_running = 0;
    end else if (!m_active) begin
      m_elec_idle = 0; m_data = ALIGN_W; m_active = 1; m_burst = 1; m_n_align++;
    end else if (!m_running) begin
      if (m_burst < AB) begin
        m_data = ALIGN_W; m_burst++; m_n_align++;
      end else begin
        m_running = 1; m_data = SYNC_W; m_since = 1;
      end
    end else if (m_since == AI) begin
      m_data = ALIGN_W; m_pair_half = 1; m_n_align++;
    end else if (valid) begin
      m_data = d; m_since++; m_n_data++;
    end else begin
      m_data = SYNC_W; m_since++;
    end
  endfunction

  // Runs one full word slot starting just after a load edge (at a negedge).
  task automatic do_slot(input string tag, input bit idle, input bit valid,
                         input logic [39:0] d, output bit accepted);
    bit          bad_timing = 0;
    bit          bad_stable = 0;
    bit          exp_rdy;
    logic [39:0] hold_data;
    logic        hold_idle;
    logic [63:0] noise;
    hold_data  = o_data;
    hold_idle  = o_elec_idle;
    i_idle_req = idle;
    s_valid    = valid;
    for (int i = 0; i < WS - 1; i++) begin
      noise  = {$urandom(), $urandom()};
      s_data = noise[39:0];
      if (o_word_strobe !== 1'b0 || s_ready !== 1'b0) bad_timing = 1;
      if (o_data !== hold_data || o_elec_idle !== hold_idle) bad_stable = 1;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    s_data  = d;
    exp_rdy = model_ready(idle);
    checks++;
    if (bad_timing || o_word_strobe !== 1'b1) begin
      errors++;
      $display("FAIL %s strobe_timing: strobe=%b at bit %0d or strobe/ready high earlier, required strobe only at bit %0d",
               tag, o_word_strobe, WS - 1, WS - 1);
    end
    checks++;
    if (s_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s s_ready: got %b required %b", tag, s_ready, exp_rdy);
    end
    checks++;
    if (bad_stable) begin
      errors++;
      $display("FAIL %s stable: outputs changed between load edges (held data %h idle %b)",
               tag, hold_data, hold_idle);
    end
    @(posedge i_clk);
    model_slot(idle, valid, d, accepted);
    #1;
    checks++;
    if (o_data !== m_data) begin
      errors++;
      $display("FAIL %s o_data: got %h required %h", tag, o_data, m_data);
    end
    checks++;
    if (o_elec_idle !== m_elec_idle) begin
      errors++;
      $display("FAIL %s o_elec_idle: got %b required %b", tag, o_elec_idle, m_elec_idle);
    end
    @(negedge i_clk);
  endtask

  // Caller must be between edges; returns at a negedge with bc=0.
  task automatic apply_reset(input string tag);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_elec_idle !== 1'b1 || o_data !== 40'd0 || o_word_strobe !== 1'b0 ||
        s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs: idle=%b data=%h strobe=%b ready=%b required 1/0/0/0",
               tag, o_elec_idle, o_data, o_word_strobe, s_ready);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic check_stats(input string tag);
`ifdef MDL_TXSCHED_STATS_EN
    checks++;
    if (o_align_count !== 32'(m_n_align)) begin
      errors++;
      $display("FAIL %s align_count: got %0d required %0d", tag, o_align_count, m_n_align);
    end
    checks++;
    if (o_data_count !== 32'(m_n_data)) begin
      errors++;
      $display("FAIL %s data_count: got %0d required %0d", tag, o_data_count, m_n_data);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic test_reset();
    bit acc;
    @(negedge i_clk);
    apply_reset("reset");
    for (int s = 0; s < 5; s++) do_slot("reset_idle", 1'b1, 1'($urandom % 2), 40'($urandom), acc);
    check_stats("reset");
  endtask

  task automatic test_wake_sync();
    bit acc;
    for (int s = 0; s < 14; s++) do_slot("wake_sync", 1'b0, 1'b0, 40'd0, acc);
    check_stats("wake_sync");
  endtask

  task automatic test_stream();
    logic [39:0] dq[10];
    int          idx = 0;
    bit          acc;
    for (int k = 0; k < 10; k++) dq[k] = {8'($urandom), 32'($urandom)};
    for (int s = 0; s < 30 && idx < 10; s++) begin
      do_slot("stream", 1'b0, 1'b1, dq[idx], acc);
      if (acc) idx++;
    end
    checks++;
    if (idx != 10) begin
      errors++;
      $display("FAIL stream accepted: got %0d words required 10 within 30 slots", idx);
    end
    check_stats("stream");
  endtask

  task automatic test_align_abort();
    bit acc;
    for (int s = 0; s < 10 && !m_pair_half; s++) do_slot("abort_pre", 1'b0, 1'($urandom % 2), 40'($urandom), acc);
    checks++;
    if (!m_pair_half) begin
      errors++;
      $display("FAIL align_abort reach_pair: first ALIGN of pair not reached, required within 10 slots");
    end
    do_slot("abort_2nd", 1'b1, 1'b1, 40'($urandom), acc);
    checks++;
    if (o_data !== ALIGN_W || o_elec_idle !== 1'b0) begin
      errors++;
      $display("FAIL align_abort second_align: got data %h idle %b required %h idle 0",
               o_data, o_elec_idle, ALIGN_W);
    end
    do_slot("abort_idle", 1'b1, 1'b1, 40'($urandom), acc);
    checks++;
    if (o_elec_idle !== 1'b1 || o_data !== 40'd0) begin
      errors++;
      $display("FAIL align_abort idle: got data %h idle %b required 0 idle 1", o_data, o_elec_idle);
    end
  endtask

  task automatic test_wake_abort();
    bit acc;
    apply_reset("wake_abort");
    do_slot("wake_abort_a", 1'b0, 1'b0, 40'd0, acc);
    do_slot("wake_abort_i", 1'b1, 1'b0, 40'd0, acc);
    checks++;
    if (o_elec_idle !== 1'b1 || o_data !== 40'd0) begin
      errors++;
      $display("FAIL wake_abort idle: got data %h idle %b required 0 idle 1", o_data, o_elec_idle);
    end
    check_stats("wake_abort");
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit seen_data = 0;
    for (int s = 0; s < 10 && !seen_data; s++) begin
      do_slot("mid_pre", 1'b0, 1'b1, {8'h5A, 32'($urandom)}, acc);
      seen_data = acc;
    end
    checks++;
    if (!seen_data) begin
      errors++;
      $display("FAIL reset_mid data_slot: no data word accepted, required one within 10 slots");
    end
    i_idle_req = 1'b0;
    s_valid    = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    apply_reset("reset_mid");
    do_slot("mid_wake1", 1'b0, 1'b1, 40'($urandom), acc);
    checks++;
    if (o_data !== ALIGN_W || o_elec_idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid wake_align: got data %h idle %b required %h idle 0",
               o_data, o_elec_idle, ALIGN_W);
    end
    do_slot("mid_wake2", 1'b0, 1'b1, 40'($urandom), acc);
    do_slot("mid_wake3", 1'b0, 1'b1, 40'($urandom), acc);
    checks++;
    if (o_data !== SYNC_W) begin
      errors++;
      $display("FAIL reset_mid first_run: got data %h required %h", o_data, SYNC_W);
    end
    check_stats("reset_mid");
  endtask

  task automatic test_random();
    bit acc;
    for (int s = 0; s < 80; s++)
      do_slot("random", ($urandom % 8) == 0, 1'($urandom % 2), {8'($urandom), 32'($urandom)}, acc);
    check_stats("random");
  endtask

  initial begin
    i_reset    = 1'b1;
    i_idle_req = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    model_reset();
    test_reset();
    test_wake_sync();
    test_stream();
    test_align_abort();
    test_wake_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
